// File: rtl/w5500_task_sched.sv
// w5500_task_sched: top-level task sequencer for the W5500 Ethernet path.
// Runs HW reset, common init and socket init, then schedules socket TX/RX passes.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   i_int_n         W5500 INTn pin (asynchronous, active-low)
//   i_tx_req        user TX request level, held until o_tx_done
//   i_cm_ini_end    common-register init complete pulse
//   i_sn_ini_end    socket init complete pulse
//   i_sn_tx_end     socket TX pass complete pulse
//   i_sn_rx_end     socket RX pass complete pulse
//   o_w5500_rst_n   W5500 hardware reset, active-low
//   o_task_state    0 RST_IDLE,1 HW_RST,2 CM_INI,3 SN_INI,4 WAIT,5 TX,6 RX
//   o_cm_ini_start  pulse on first cycle of CM_INI
//   o_sn_ini_ctl    pulse on first cycle of SN_INI
//   o_tx_done       pulse when a TX pass completes
//   o_ready         high in WAIT, TX or RX
//   o_tmo_err       pulse on watchdog expiry
module w5500_task_sched #(
    parameter int unsigned HW_RST_CYC  = 500,
    parameter int unsigned HW_WAIT_CYC = 50000,
    parameter int unsigned POLL_CYC    = 50000,
    parameter int unsigned TMO_CYC     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_int_n,
    input  logic       i_tx_req,
    input  logic       i_cm_ini_end,
    input  logic       i_sn_ini_end,
    input  logic       i_sn_tx_end,
    input  logic       i_sn_rx_end,
    output logic       o_w5500_rst_n,
    output logic [3:0] o_task_state,
    output logic       o_cm_ini_start,
    output logic       o_sn_ini_ctl,
    output logic       o_tx_done,
    output logic       o_ready,
    output logic       o_tmo_err
);

    typedef enum logic [3:0] {
        ST_RST_IDLE = 4'd0,
        ST_HW_RST   = 4'd1,
        ST_CM_INI   = 4'd2,
        ST_SN_INI   = 4'd3,
        ST_WAIT     = 4'd4,
        ST_TX       = 4'd5,
        ST_RX       = 4'd6
    } state_t;

    localparam logic [31:0] RST_LEN   = 32'(HW_RST_CYC);
    localparam logic [31:0] HW_LAST   = 32'(HW_RST_CYC + HW_WAIT_CYC - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TMO_CYC - 1);

    state_t      st, st_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] poll;
    logic        int_s1, int_s2, int_s3;
    logic        rx_pend, last_tx;
    logic        tx_pend, rx_set, rx_want, poll_hit, poll_run;
    logic        grant_tx, grant_rx, tmo, tx_done_nx, wd_on;

    assign o_task_state = st;

    assign poll_run = (st == ST_WAIT) || (st == ST_TX);
    assign poll_hit = poll_run && (poll == POLL_LAST);
    assign tx_pend  = (st == ST_WAIT) && i_tx_req;
    // Falling edge anywhere, low level only while idle in WAIT.
    assign rx_set   = (int_s3 && !int_s2)
                    || ((st == ST_WAIT) && !int_s2)
                    || poll_hit;
    assign rx_want  = rx_pend || rx_set;
    assign wd_on    = (st == ST_CM_INI) || (st == ST_SN_INI)
                    || (st == ST_TX) || (st == ST_RX);

    always_comb begin
        st_nx      = st;
        grant_tx   = 1'b0;
        grant_rx   = 1'b0;
        tx_done_nx = 1'b0;
        tmo        = 1'b0;
        case (st)
            ST_RST_IDLE: st_nx = ST_HW_RST;
            ST_HW_RST:   if (cnt == HW_LAST) st_nx = ST_CM_INI;
            ST_CM_INI:   if (i_cm_ini_end) st_nx = ST_SN_INI;
            ST_SN_INI:   if (i_sn_ini_end) st_nx = ST_WAIT;
            ST_WAIT: begin
                if (tx_pend && rx_want) begin
                    grant_tx = !last_tx;
                    grant_rx = last_tx;
                end else begin
                    grant_tx = tx_pend;
                    grant_rx = rx_want;
                end
                if (grant_tx)      st_nx = ST_TX;
                else if (grant_rx) st_nx = ST_RX;
            end
            ST_TX: begin
                if (i_sn_tx_end) begin
                    st_nx      = ST_WAIT;
                    tx_done_nx = 1'b1;
                end
            end
            ST_RX:   if (i_sn_rx_end) st_nx = ST_WAIT;
            default: st_nx = ST_RST_IDLE;
        endcase
        // An end pulse on the expiry cycle already moved st_nx, so it wins.
        if (wd_on && (cnt == TMO_LAST) && (st_nx == st)) begin
            tmo   = 1'b1;
            st_nx = ST_HW_RST;
        end
        cnt_nx = (st_nx != st) ? 32'd0 : cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st             <= ST_RST_IDLE;
            cnt            <= 32'd0;
            poll           <= 32'd0;
            int_s1         <= 1'b1;
            int_s2         <= 1'b1;
            int_s3         <= 1'b1;
            rx_pend        <= 1'b0;
            last_tx        <= 1'b0;
            o_w5500_rst_n  <= 1'b0;
            o_cm_ini_start <= 1'b0;
            o_sn_ini_ctl   <= 1'b0;
            o_tx_done      <= 1'b0;
            o_ready        <= 1'b0;
            o_tmo_err      <= 1'b0;
        end else begin
            st     <= st_nx;
            cnt    <= cnt_nx;
            int_s1 <= i_int_n;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
            poll   <= (poll_run && !poll_hit) ? poll + 32'd1 : 32'd0;
            // Clear beats a same-cycle set.
            if (tmo || (st_nx == ST_RX && st != ST_RX)) rx_pend <= 1'b0;
            else if (rx_set)                            rx_pend <= 1'b1;
            if (grant_tx)      last_tx <= 1'b1;
            else if (grant_rx) last_tx <= 1'b0;
            o_w5500_rst_n  <= !((st_nx == ST_RST_IDLE)
                            || ((st_nx == ST_HW_RST) && (cnt_nx < RST_LEN)));
            o_cm_ini_start <= (st_nx == ST_CM_INI) && (st != ST_CM_INI);
            o_sn_ini_ctl   <= (st_nx == ST_SN_INI) && (st != ST_SN_INI);
            o_tx_done      <= tx_done_nx;
            o_ready        <= (st_nx == ST_WAIT) || (st_nx == ST_TX)
                            || (st_nx == ST_RX);
            o_tmo_err      <= tmo;
        end
    end

endmodule
